// File: rtl/input_debouncer.sv
// input_debouncer
//   Turns one raw asynchronous level (button, off-chip strobe, external flag) into a clean,
//   synchronous level that changes only after DEBOUNCE_CYCLES consecutive identical samples.
//   Rejected candidate changes produce a one-cycle glitch pulse and bump a saturating counter.
//
// Ports:
//   clk           sole clock, all logic on posedge
//   rst           synchronous active-high reset
//   raw_in        asynchronous raw level
//   glitch_clr    synchronous clear of glitch_count (wins over a simultaneous glitch)
//   clean_out     debounced level
//   busy          high while a candidate level change is being qualified
//   glitch        one-cycle pulse when a candidate change is rejected
//   glitch_count  saturating count of glitch pulses
module input_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0,
  parameter int unsigned GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  input  logic                glitch_clr,
  output logic                clean_out,
  output logic                busy,
  output logic                glitch,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {StStable, StCheck} state_e;

  // Synchronizer: only sync_q[0] may go metastable; nothing reads it except sync_q[1].
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM
  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                clean_q, clean_d;
  logic                glitch_q, glitch_d;
  logic [GLITCH_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StStable;
      cnt_q    <= '0;
      clean_q  <= RESET_LEVEL;
      glitch_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      glitch_q <= glitch_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    glitch_d = 1'b0;
    case (state_q)
      StStable: begin
        if (s != clean_q) begin
          state_d = StCheck;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StCheck: begin
        if (s == clean_q) begin
          // Run broken before qualifying: reject the candidate.
          state_d  = StStable;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CntLast) begin
          // This edge supplies the DEBOUNCE_CYCLES-th consecutive differing sample.
          clean_d = s;
          state_d = StStable;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StStable;
        cnt_d   = '0;
      end
    endcase
  end

  // Counts the registered glitch pulse, so a clear during the pulse cycle wins.
  always_comb begin
    count_d = count_q;
    if (glitch_clr) begin
      count_d = '0;
    end else if (glitch_q && (count_q != {GLITCH_W{1'b1}})) begin
      count_d = count_q + GLITCH_W'(1);
    end
  end

  assign clean_out    = clean_q;
  assign busy         = (state_q == StCheck);
  assign glitch       = glitch_q;
  assign glitch_count = count_q;

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_in;
  logic       glitch_clr;
  logic       clean_out;
  logic       busy;
  logic       glitch;
  logic [7:0] glitch_count;

  int total = 0;
  int bad   = 0;

  input_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .RESET_LEVEL    (1'b0),
    .GLITCH_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .raw_in      (raw_in),
    .glitch_clr  (glitch_clr),
    .clean_out   (clean_out),
    .busy        (busy),
    .glitch      (glitch),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  // Advance one posedge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    raw_in     = 1'b0;
    glitch_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  // 5-cycle high pulse on raw_in followed by 8 idle cycles.
  task automatic pulse5();
    raw_in = 1'b1;
    repeat (5) tick();
    raw_in = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    raw_in     = 1'b1;
    glitch_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (clean_out !== 1'b0) begin
        bad++; $display("FAIL reset_clean cyc=%0d got=%b exp=0", i, clean_out);
      end
      total++;
      if (busy !== 1'b0) begin
        bad++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy);
      end
      total++;
      if (glitch_count !== 8'd0) begin
        bad++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, glitch_count);
      end
    end
    rst = 1'b0;
    // raw_in=1 is first sampled at this edge; busy rises two edges later.
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (busy !== (n == 2)) begin
        bad++; $display("FAIL release_busy n=%0d got=%b exp=%b", n, busy, (n == 2));
      end
      total++;
      if (clean_out !== 1'b0) begin
        bad++; $display("FAIL release_clean n=%0d got=%b exp=0", n, clean_out);
      end
    end
    total++;
    if (glitch_count !== 8'd0) begin
      bad++; $display("FAIL release_count got=%0d exp=0", glitch_count);
    end
  endtask

  task automatic test_clean_step();
    logic exp_busy;
    logic exp_clean;
    do_reset();
    raw_in = 1'b1;
    for (int n = 0; n <= 18; n++) begin
      tick();
      exp_busy  = (n >= 2) && (n < 17);
      exp_clean = (n >= 17);
      total++;
      if (busy !== exp_busy) begin
        bad++; $display("FAIL step_busy n=%0d got=%b exp=%b", n, busy, exp_busy);
      end
      total++;
      if (clean_out !== exp_clean) begin
        bad++; $display("FAIL step_clean n=%0d got=%b exp=%b", n, clean_out, exp_clean);
      end
      total++;
      if (glitch !== 1'b0) begin
        bad++; $display("FAIL step_glitch n=%0d got=%b exp=0", n, glitch);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses;
    do_reset();
    pulses = 0;
    raw_in = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      if (n == 5) raw_in = 1'b0;
      tick();
      if (glitch === 1'b1) pulses++;
      total++;
      if (glitch !== (n == 7)) begin
        bad++; $display("FAIL glitch_pulse n=%0d got=%b exp=%b", n, glitch, (n == 7));
      end
      total++;
      if (clean_out !== 1'b0) begin
        bad++; $display("FAIL glitch_clean n=%0d got=%b exp=0", n, clean_out);
      end
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL glitch_npulses got=%0d exp=1", pulses);
    end
    total++;
    if (glitch_count !== 8'd1) begin
      bad++; $display("FAIL glitch_count1 got=%0d exp=1", glitch_count);
    end
    for (int i = 1; i < 300; i++) begin
      pulse5();
      if (i == 253) begin
        total++;
        if (glitch_count !== 8'd254) begin
          bad++; $display("FAIL glitch_count254 got=%0d exp=254", glitch_count);
        end
      end
    end
    total++;
    if (glitch_count !== 8'd255) begin
      bad++; $display("FAIL glitch_saturate got=%0d exp=255", glitch_count);
    end
    total++;
    if (clean_out !== 1'b0) begin
      bad++; $display("FAIL glitch_sat_clean got=%b exp=0", clean_out);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      raw_in = ((c / 3) % 2) == 0;
      tick();
      total++;
      if (clean_out !== 1'b0) begin
        bad++; $display("FAIL bounce_clean c=%0d got=%b exp=0", c, clean_out);
      end
    end
    raw_in = 1'b1;
    for (int n = 0; n <= 18; n++) begin
      tick();
      total++;
      if (clean_out !== (n >= 17)) begin
        bad++; $display("FAIL bounce_final n=%0d got=%b exp=%b", n, clean_out, (n >= 17));
      end
    end
    // Seven high segments, each rejected.
    total++;
    if (glitch_count !== 8'd7) begin
      bad++; $display("FAIL bounce_count got=%0d exp=7", glitch_count);
    end
  endtask

  // Runs after test_bounce: clean_out=1, raw_in=1, glitch_count=7.
  task automatic test_clear_priority();
    raw_in = 1'b0;
    repeat (2) tick();
    raw_in = 1'b1;
    repeat (3) tick();
    total++;
    if (glitch !== 1'b1) begin
      bad++; $display("FAIL clr_glitch_pulse got=%b exp=1", glitch);
    end
    total++;
    if (glitch_count !== 8'd7) begin
      bad++; $display("FAIL clr_count_before got=%0d exp=7", glitch_count);
    end
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    total++;
    if (glitch_count !== 8'd0) begin
      bad++; $display("FAIL clr_priority got=%0d exp=0", glitch_count);
    end
    repeat (3) tick();
    total++;
    if (glitch_count !== 8'd0) begin
      bad++; $display("FAIL clr_hold got=%0d exp=0", glitch_count);
    end
    total++;
    if (clean_out !== 1'b1) begin
      bad++; $display("FAIL clr_clean got=%b exp=1", clean_out);
    end
  endtask

  task automatic test_reset_mid_qualify();
    do_reset();
    raw_in = 1'b1;
    // Edge k, then k+1..k+11: cnt reaches 10 after edge k+11.
    repeat (12) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midq_busy_before got=%b exp=1", busy);
    end
    rst = 1'b1;
    tick();
    total++;
    if (clean_out !== 1'b0) begin
      bad++; $display("FAIL midq_clean got=%b exp=0", clean_out);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL midq_busy got=%b exp=0", busy);
    end
    total++;
    if (glitch !== 1'b0) begin
      bad++; $display("FAIL midq_glitch got=%b exp=0", glitch);
    end
    raw_in = 1'b0;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      total++;
      if (glitch !== 1'b0) begin
        bad++; $display("FAIL midq_glitch_after n=%0d got=%b exp=0", n, glitch);
      end
    end
    total++;
    if (glitch_count !== 8'd0) begin
      bad++; $display("FAIL midq_count got=%0d exp=0", glitch_count);
    end
    total++;
    if (clean_out !== 1'b0) begin
      bad++; $display("FAIL midq_clean_after got=%b exp=0", clean_out);
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_clear_priority();
    test_reset_mid_qualify();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
